// File: rtl/sram_arbiter.sv
// Two-requester arbiter/sequencer for a 64Kx16 single-port synchronous-write SRAM.
// Optional macro SRAM_ARB_RR_EN: round-robin arbitration instead of fixed priority with starvation override.
module sram_arbiter #(
  parameter int AW           = 16,
  parameter int DW           = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          R0_REQ,
  input  logic          R0_WE,
  input  logic [AW-1:0] R0_A,
  input  logic [DW-1:0] R0_DIN,
  output logic          R0_GNT,
  output logic [DW-1:0] R0_DOUT,
  output logic          R0_VALID,
  input  logic          R1_REQ,
  input  logic          R1_WE,
  input  logic [AW-1:0] R1_A,
  input  logic [DW-1:0] R1_DIN,
  output logic          R1_GNT,
  output logic [DW-1:0] R1_DOUT,
  output logic          R1_VALID,
  output logic          M_WE,
  output logic [AW-1:0] M_A,
  output logic [DW-1:0] M_DIN,
  input  logic [DW-1:0] M_DOUT
);

  logic          gnt0, gnt1, accept;
  logic          m_we_q, m_we_d;
  logic [AW-1:0] m_a_q, m_a_d;
  logic [DW-1:0] m_din_q, m_din_d;
  logic          pend_q, pend_d;
  logic          owner_q, owner_d;
  logic          prd_q, prd_d;
  logic          r0_valid_q, r0_valid_d, r1_valid_q, r1_valid_d;
  logic [DW-1:0] r0_dout_q, r0_dout_d, r1_dout_q, r1_dout_d;

`ifdef SRAM_ARB_RR_EN
  // Requester favoured on a tie; always the one that did not win the last accept.
  logic          prio_q, prio_d;
`else
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic [3:0]    starve_q, starve_d;
`endif

  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!RST) begin
`ifdef SRAM_ARB_RR_EN
      if (R0_REQ && R1_REQ) begin
        gnt0 = ~prio_q;
        gnt1 = prio_q;
      end else begin
        gnt0 = R0_REQ;
        gnt1 = R1_REQ;
      end
`else
      if (R0_REQ && starve_q == LIMIT) gnt0 = 1'b1;
      else if (R1_REQ)                 gnt1 = 1'b1;
      else                             gnt0 = R0_REQ;
`endif
    end
  end

  assign accept = gnt0 | gnt1;

`ifdef SRAM_ARB_RR_EN
  always_comb begin
    prio_d = prio_q;
    if (accept) prio_d = ~gnt1;
  end
`else
  always_comb begin
    starve_d = 4'd0;
    if (R0_REQ && !gnt0) starve_d = (starve_q == LIMIT) ? starve_q : starve_q + 4'd1;
  end
`endif

  always_comb begin
    m_we_d  = 1'b0;
    m_a_d   = m_a_q;
    m_din_d = m_din_q;
    pend_d  = 1'b0;
    owner_d = owner_q;
    prd_d   = 1'b0;
    if (accept) begin
      m_we_d  = gnt1 ? R1_WE  : R0_WE;
      m_a_d   = gnt1 ? R1_A   : R0_A;
      m_din_d = gnt1 ? R1_DIN : R0_DIN;
      pend_d  = 1'b1;
      owner_d = gnt1;
      prd_d   = gnt1 ? !R1_WE : !R0_WE;
    end
    // Read data for the access launched last cycle is on M_DOUT now.
    r0_valid_d = pend_q && prd_q && !owner_q;
    r1_valid_d = pend_q && prd_q &&  owner_q;
    r0_dout_d  = r0_valid_d ? M_DOUT : r0_dout_q;
    r1_dout_d  = r1_valid_d ? M_DOUT : r1_dout_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      m_we_q     <= 1'b0;
      m_a_q      <= '0;
      m_din_q    <= '0;
      pend_q     <= 1'b0;
      owner_q    <= 1'b0;
      prd_q      <= 1'b0;
      r0_valid_q <= 1'b0;
      r1_valid_q <= 1'b0;
      r0_dout_q  <= '0;
      r1_dout_q  <= '0;
`ifdef SRAM_ARB_RR_EN
      prio_q     <= 1'b0;
`else
      starve_q   <= 4'd0;
`endif
    end else begin
      m_we_q     <= m_we_d;
      m_a_q      <= m_a_d;
      m_din_q    <= m_din_d;
      pend_q     <= pend_d;
      owner_q    <= owner_d;
      prd_q      <= prd_d;
      r0_valid_q <= r0_valid_d;
      r1_valid_q <= r1_valid_d;
      r0_dout_q  <= r0_dout_d;
      r1_dout_q  <= r1_dout_d;
`ifdef SRAM_ARB_RR_EN
      prio_q     <= prio_d;
`else
      starve_q   <= starve_d;
`endif
    end
  end

  assign R0_GNT   = gnt0;
  assign R1_GNT   = gnt1;
  assign R0_DOUT  = r0_dout_q;
  assign R1_DOUT  = r1_dout_q;
  assign R0_VALID = r0_valid_q;
  assign R1_VALID = r1_valid_q;
  assign M_WE     = m_we_q;
  assign M_A      = m_a_q;
  assign M_DIN    = m_din_q;

endmodule
